// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM that drives the Maxnet datapath load strobes and reports the outcome
module maxnet_controller #(
    parameter int PU_LAT   = 3,
    parameter int MAX_ITER = 63,
    parameter int ITER_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    input  logic [3:0]        zeros,
    output logic              ldI,
    output logic              ldInit,
    output logic              ldA,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              tie,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    localparam int WW = PU_LAT > 1 ? $clog2(PU_LAT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(PU_LAT > 0 ? PU_LAT - 1 : 0);
    localparam logic [ITER_W-1:0] ILAST = ITER_W'(MAX_ITER);
    typedef enum logic [2:0] {IDLE, LOADX, INIT, CHECK, WAIT, UPDATE, DONE} state_t;
    state_t state, state_n;
    logic [WW-1:0] wcnt;
    logic [2:0] n;
    logic at_limit;
    always_comb begin
        n = 3'($countones(~zeros));
        at_limit = iter_count == ILAST;
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOADX : IDLE;
            LOADX:   state_n = INIT;
            INIT:    state_n = CHECK;
            CHECK:   state_n = (n <= 3'd1 || at_limit) ? DONE : (PU_LAT == 0 ? UPDATE : WAIT);
            WAIT:    state_n = wcnt == WLAST ? UPDATE : WAIT;
            UPDATE:  state_n = CHECK;
            DONE:    state_n = ack ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    assign ldI    = state == LOADX;
    assign ldInit = state == INIT;
    assign ldA    = state == UPDATE;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            tie        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= (state == WAIT && state_n == WAIT) ? wcnt + 1'b1 : '0;
            if (state == LOADX) begin
                iter_count <= '0;
                converged  <= 1'b0;
                tie        <= 1'b0;
                timeout    <= 1'b0;
            end
            if (state == UPDATE)
                iter_count <= iter_count + 1'b1;
            // single-winner outranks tie, which outranks the iteration limit
            if (state == CHECK) begin
                converged <= n == 3'd1;
                tie       <= n == 3'd0;
                timeout   <= n > 3'd1 && at_limit;
            end
        end
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: table-driven scoreboard bench for maxnet_controller (PU_LAT=3 and PU_LAT=0 instances)
module tb_maxnet_controller;
    typedef struct packed {
        logic        sel;
        logic [19:0] sched;
        int          done_cyc;
        int          iter;
        logic [2:0]  flags;
        logic        poke;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, ack, sel;
    logic [3:0] zeros;
    logic s_start, s_ack, f_start, f_ack;
    logic s_ldI, s_ldInit, s_ldA, s_busy, s_done, s_conv, s_tie, s_to;
    logic f_ldI, f_ldInit, f_ldA, f_busy, f_done, f_conv, f_tie, f_to;
    logic [5:0] s_it, f_it;
    logic o_ldI, o_ldInit, o_ldA, o_busy, o_done, o_conv, o_tie, o_to;
    logic [5:0] o_it;
    int errors = 0;
    int checks = 0;
    vec_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    assign s_start = start & ~sel;
    assign s_ack = ack & ~sel;
    assign f_start = start & sel;
    assign f_ack = ack & sel;
    assign o_ldI = sel ? f_ldI : s_ldI;
    assign o_ldInit = sel ? f_ldInit : s_ldInit;
    assign o_ldA = sel ? f_ldA : s_ldA;
    assign o_busy = sel ? f_busy : s_busy;
    assign o_done = sel ? f_done : s_done;
    assign o_conv = sel ? f_conv : s_conv;
    assign o_tie = sel ? f_tie : s_tie;
    assign o_to = sel ? f_to : s_to;
    assign o_it = sel ? f_it : s_it;

    maxnet_controller #(.PU_LAT(3), .MAX_ITER(4), .ITER_W(6)) dut (
        .clk(clk), .rst(rst), .start(s_start), .ack(s_ack), .zeros(zeros),
        .ldI(s_ldI), .ldInit(s_ldInit), .ldA(s_ldA), .busy(s_busy), .done(s_done),
        .converged(s_conv), .tie(s_tie), .timeout(s_to), .iter_count(s_it)
    );

    maxnet_controller #(.PU_LAT(0), .MAX_ITER(4), .ITER_W(6)) dut_fast (
        .clk(clk), .rst(rst), .start(f_start), .ack(f_ack), .zeros(zeros),
        .ldI(f_ldI), .ldInit(f_ldInit), .ldA(f_ldA), .busy(f_busy), .done(f_done),
        .converged(f_conv), .tie(f_tie), .timeout(f_to), .iter_count(f_it)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [3:0] z0, z1, z2, z3, z4,
                                input int dc, input int it, input logic [2:0] fl, input logic pk);
        vec_t v;
        v.sel = s;
        v.sched = {z4, z3, z2, z1, z0};
        v.done_cyc = dc;
        v.iter = it;
        v.flags = fl;
        v.poke = pk;
        return v;
    endfunction

    // zeros emulates the datapath: it takes the next scheduled pattern one edge after ldInit/ldA
    task automatic run(input vec_t v);
        int cyc, nlda, ldi_c, ldinit_c, multi, k, pl;
        logic pi, pa, got;
        vec_t e;
        sel = v.sel;
        pl = v.sel ? 0 : 3;
        zeros = 4'b1111;
        sb.push_back(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; nlda = 0; ldi_c = -1; ldinit_c = -1; multi = 0; k = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            if (v.poke) begin
                start = cyc >= 3 && cyc <= 5;
                ack = cyc >= 5 && cyc <= 7;
            end
            if (int'(o_ldI) + int'(o_ldInit) + int'(o_ldA) > 1) multi++;
            if (o_ldI) ldi_c = cyc;
            if (o_ldInit) ldinit_c = cyc;
            if (o_ldA) begin
                chk("lda_cycle", cyc, 4 + pl + nlda * (pl + 2));
                nlda++;
            end
            if (o_done) got = 1'b1;
            else begin
                pi = o_ldInit;
                pa = o_ldA;
                @(posedge clk); #1;
                cyc++;
                if (pi) begin zeros = v.sched[3:0]; k = 1; end
                if (pa) begin zeros = v.sched[4*k +: 4]; if (k < 4) k++; end
            end
        end
        start = 1'b0;
        ack = 1'b0;
        e = sb.pop_front();
        chk("done_seen", int'(got), 1);
        if (!got) return;
        chk("done_cycle", cyc, e.done_cyc);
        chk("iter_count", int'(o_it), e.iter);
        chk("flags", int'({o_conv, o_tie, o_to}), int'(e.flags));
        chk("lda_pulses", nlda, e.iter);
        chk("ldI_cycle", ldi_c, 1);
        chk("ldInit_cycle", ldinit_c, 2);
        chk("strobe_overlap", multi, 0);
        chk("busy_in_done", int'(o_busy), 1);
        @(posedge clk); #1;
        chk("done_hold", int'(o_done), 1);
        chk("iter_hold", int'(o_it), e.iter);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("idle_after_ack", int'({o_busy, o_done, o_ldI, o_ldInit, o_ldA}), 0);
        chk("flags_idle", int'({o_conv, o_tie, o_to}), int'(e.flags));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(0, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4, 0, 3'b100, 0);
        vecs[1] = mk(0, 4'b0000, 4'b0000, 4'b0100, 4'b0111, 4'b0111, 19, 3, 3'b100, 1);
        vecs[2] = mk(0, 4'b0000, 4'b0011, 4'b1111, 4'b1111, 4'b1111, 14, 2, 3'b010, 1);
        vecs[3] = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24, 4, 3'b001, 1);
        vecs[4] = mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4, 0, 3'b010, 0);
        vecs[5] = mk(0, 4'b1000, 4'b1010, 4'b1011, 4'b1011, 4'b1011, 14, 2, 3'b100, 1);
        vecs[6] = mk(1, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 8, 2, 3'b100, 0);
        vecs[7] = mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4, 0, 3'b010, 0);
        vecs[8] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12, 4, 3'b001, 0);
        sel = 1'b0;
        ack = 1'b0;
        zeros = 4'b1111;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({o_ldI, o_ldInit, o_ldA, o_busy, o_done, o_conv, o_tie, o_to}), 0);
        chk("reset_iter", int'(o_it), 0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_lost", int'({o_busy, o_ldI}), 0);
        foreach (vecs[i]) run(vecs[i]);
        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_clears_flags", int'({o_conv, o_tie, o_to}), 0);
        chk("rst_clears_iter", int'(o_it), 0);
        sel = 1'b0;
        zeros = 4'b0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrun_iter", int'(o_it), 1);
        chk("midrun_busy", int'(o_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset_outputs", int'({o_ldI, o_ldInit, o_ldA, o_busy, o_done, o_conv, o_tie, o_to}), 0);
        chk("midrun_reset_iter", int'(o_it), 0);
        run(vecs[1]);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
